mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Iterative MIPS multiply/divide unit holding the architectural HI/LO registers. It sits directly downstream of the 32-entry register file: operandA/operandB are driven from readData1/readData2. It executes MULT, MULTU, DIV and DIVU over multiple cycles under a start/busy/done handshake. MFHI/MFLO read hi/lo combinationally; MTHI/MTLO write them directly.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH bits each; iteration count = WIDTH

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset; asserting low clears all state immediately
start  input  1  request to begin operation op; sampled only in IDLE
op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
operandA  input  WIDTH  rs value (multiplicand / dividend)
operandB  input  WIDTH  rt value (multiplier / divisor)
hiWrite  input  1  MTHI: load hi from writeData
loWrite  input  1  MTLO: load lo from writeData
writeData  input  WIDTH  data for hiWrite/loWrite
busy  output  1  operation in progress
done  output  1  one-cycle pulse: hi/lo hold the new result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rst=0, any time, including mid-operation): state=IDLE, busy=0, done=0, hi=0, lo=0, all internal counters/accumulators 0. The in-flight operation is discarded.
- States: IDLE, COMPUTE, FIXUP.
- IDLE: start=1 at edge E0 latches operands as magnitudes, plus the result sign flags for signed ops and the op code. State goes to COMPUTE, counter=0, busy=1.
- COMPUTE: one radix-2 step per edge (shift-add multiply, restoring divide). Edges E1..E32 perform the 32 steps. After E32, state=FIXUP.
- FIXUP, edge E33:
  - Apply two's-complement sign correction.
  - Write hi/lo.
  - done=1 for exactly one cycle; busy=0; state=IDLE.
- Latency: done is visible in the cycle after E33 (33 cycles after start was sampled). busy is high from after E0 through E33.
- A new start may be sampled in the same cycle done=1, since the unit is already in IDLE.
- start while busy: ignored, with no effect on the current operation.
- MULT: signed 64-bit product; hi = product[63:32], lo = product[31:0]. MULTU: unsigned product, same split.
- DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Divide by zero (operandB=0, DIV or DIVU): full latency; lo=32'hFFFFFFFF, hi=operandA.
- DIV overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- hiWrite/loWrite: take effect at the edge only in IDLE; ignored while busy.
- start and hiWrite/loWrite in the same IDLE cycle: start wins and the writes are dropped.
- hiWrite and loWrite together: both registers are written.
- hi/lo hold their previous values throughout COMPUTE; no partial results are exposed.

Optional Feature:
MDU_FAST_MULT_EN
- Defined: MULT/MULTU use a single-cycle combinational 32x32 multiplier and bypass COMPUTE. Start at E0 goes to FIXUP; hi/lo are written at E1; done is high in the cycle after E1; busy is high for one cycle. DIV/DIVU are unchanged (33 cycles).
- Undefined: all ops are iterative with 33-cycle latency, and no hardware multiplier is inferred.

Test Plan:
- MULT 0xFFFFFFFF x 0x00000002 -> done 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFFE; busy high exactly 33 cycles.
- MULTU 0xFFFFFFFF x 0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=0x00000005; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Drive start, hiWrite(writeData=0x1234) and a second start while busy -> first op completes normally, hi not 0x1234, second start ignored. Then hiWrite=1, loWrite=1 in IDLE with writeData=0xABCD -> hi=lo=0xABCD next cycle.
- Assert rst low at cycle 10 of a DIV -> busy, done, hi, lo all 0 immediately. Release rst, then issue MULTU 3x4 -> hi=0, lo=0x0000000C after full latency.

Source files
------------

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MIPS multiply/divide unit holding HI/LO
// Optional MDU_FAST_MULT_EN: single-cycle MULT/MULTU through a combinational multiplier.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, COMPUTE, FIXUP} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0] magB;
    logic             isDiv;
    logic             negLo;
    logic             negHi;

    logic             signedOp;
    logic             signA;
    logic             signB;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;

    assign signedOp = ~op[0];
    assign signA    = signedOp & operandA[WIDTH-1];
    assign signB    = signedOp & operandB[WIDTH-1];
    assign absA     = signA ? -operandA : operandA;
    assign absB     = signB ? -operandB : operandB;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifting right.
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;
    assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, magB} : '0);
    assign mulNext = {mulSum, acc[WIDTH-1:1]};

    // Restoring divide: acc = {remainder, dividend bits becoming quotient bits}.
    logic [WIDTH:0]     divTrial;
    logic [WIDTH-1:0]   divDiff;
    logic               divGeq;
    logic [2*WIDTH-1:0] divNext;
    assign divTrial = acc[2*WIDTH-1:WIDTH-1];
    assign divGeq   = divTrial >= {1'b0, magB};
    assign divDiff  = divTrial[WIDTH-1:0] - magB;
    assign divNext  = divGeq ? {divDiff, acc[WIDTH-2:0], 1'b1}
                             : {divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

`ifdef MDU_FAST_MULT_EN
    logic [2*WIDTH-1:0] fastProduct;
    assign fastProduct = {{WIDTH{1'b0}}, absA} * {{WIDTH{1'b0}}, absB};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            count <= '0;
            acc   <= '0;
            magB  <= '0;
            isDiv <= 1'b0;
            negLo <= 1'b0;
            negHi <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= {{WIDTH{1'b0}}, absA};
                        magB  <= absB;
                        isDiv <= op[1];
                        // A zero divisor leaves the quotient all-ones and unsigned,
                        // while the remainder returns the dividend unchanged.
                        negLo <= (signA ^ signB) & ~(op[1] & (operandB == '0));
                        negHi <= signA;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= COMPUTE;
`ifdef MDU_FAST_MULT_EN
                        if (!op[1]) begin
                            acc   <= fastProduct;
                            state <= FIXUP;
                        end
`endif
                    end else begin
                        if (hiWrite) hi <= writeData;
                        if (loWrite) lo <= writeData;
                    end
                end
                COMPUTE: begin
                    acc   <= isDiv ? divNext : mulNext;
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) state <= FIXUP;
                end
                FIXUP: begin
                    if (isDiv) begin
                        lo <= negLo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        hi <= negHi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                    end else begin
                        {hi, lo} <= negLo ? -acc : acc;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operandA = '0;
    logic [31:0] operandB = '0;
    logic        hiWrite = 1'b0;
    logic        loWrite = 1'b0;
    logic [31:0] writeData = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int testCnt = 0;
    int failCnt = 0;

    localparam int DIV_LAT = 33;
`ifdef MDU_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .operandA(operandA), .operandB(operandB),
        .hiWrite(hiWrite), .loWrite(loWrite), .writeData(writeData),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op and wait for done; optionally write hi alongside start,
    // or inject a start+hiWrite pulse while busy at cycle injectAt.
    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo,
                         input int expLat, input logic writeWithStart, input int injectAt);
        int cycles;
        int busyCnt;
        @(negedge clk);
        start = 1'b1; op = o; operandA = a; operandB = b;
        hiWrite = writeWithStart; writeData = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; hiWrite = 1'b0;
        cycles = 0;
        busyCnt = 0;
        while (!done && cycles < 100) begin
            if (busy) busyCnt++;
            if (cycles == injectAt) begin
                start = 1'b1; op = 2'b00; operandA = 32'h7; operandB = 32'h9;
                hiWrite = 1'b1; writeData = 32'h1234;
            end
            @(negedge clk);
            start = 1'b0; hiWrite = 1'b0;
            cycles++;
        end
        check({tag, "_latency"}, 64'(cycles), 64'(expLat));
        check({tag, "_busy"}, 64'(busyCnt), 64'(expLat));
        check({tag, "_hi"}, {32'h0, hi}, {32'h0, expHi});
        check({tag, "_lo"}, {32'h0, lo}, {32'h0, expLo});
    endtask

    initial begin
        #12;
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_done", {63'h0, done}, 64'h0);
        check("reset_hilo", {hi, lo}, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        runOp("mult_neg", 2'b00, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, 1'b0, -1);
        runOp("multu", 2'b01, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE, MUL_LAT, 1'b0, -1);
        runOp("div_neg", 2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT, 1'b0, -1);
        runOp("divu", 2'b11, 32'd100, 32'd7, 32'h2, 32'hE, DIV_LAT, 1'b1, -1);
        runOp("divu_zero", 2'b11, 32'd5, 32'd0, 32'h5, 32'hFFFFFFFF, DIV_LAT, 1'b0, -1);
        runOp("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, DIV_LAT, 1'b0, -1);
        runOp("div_zero_s", 2'b10, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, DIV_LAT, 1'b0, -1);
        runOp("mult_pos", 2'b00, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0, 32'hF, MUL_LAT, 1'b0, -1);
        runOp("busy_inject", 2'b11, 32'd15, 32'd4, 32'h3, 32'h3, DIV_LAT, 1'b0, 5);

        @(negedge clk);
        check("second_start_ignored", {63'h0, busy}, 64'h0);

        hiWrite = 1'b1; loWrite = 1'b1; writeData = 32'hABCD;
        @(negedge clk);
        hiWrite = 1'b0; loWrite = 1'b0;
        check("mthi_mtlo", {hi, lo}, {32'hABCD, 32'hABCD});

        start = 1'b1; op = 2'b10; operandA = 32'd1000; operandB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_div_busy", {63'h0, busy}, 64'h1);
        rst = 1'b0;
        #1;
        check("async_rst_busy", {63'h0, busy}, 64'h0);
        check("async_rst_done", {63'h0, done}, 64'h0);
        check("async_rst_hilo", {hi, lo}, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        runOp("multu_after_rst", 2'b01, 32'd3, 32'd4, 32'h0, 32'hC, MUL_LAT, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
